// File: rtl/ft232h_host.sv
// FT232H 245 synchronous FIFO master: a TX holding register feeds write bursts, read bursts fill an RX FIFO,
// and the shared adbus is turned around between them. The pin outputs are registered from the next state.
module ft232h_host #(
   parameter int RX_DEPTH  = 16,
   parameter int MAX_BURST = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   inout  logic [7:0]                adbus,
   input  logic                      txe,
   output logic                      wr,
   output logic                      siwu,
   input  logic                      rxf,
   output logic                      oe,
   output logic                      rd,
   input  logic [7:0]                tx_data,
   input  logic                      tx_valid,
   output logic                      tx_ready,
   output logic [7:0]                rx_data,
   output logic                      rx_valid,
   input  logic                      rx_ready,
   input  logic                      flush,
   output logic [$clog2(RX_DEPTH):0] rx_level
);

   localparam int AW = $clog2(RX_DEPTH);
   localparam int LW = AW + 1;
   localparam int BW = $clog2(MAX_BURST + 1);
   localparam logic [LW-1:0] DEPTH_L = LW'(RX_DEPTH);
   localparam logic [BW-1:0] BURST_L = BW'(MAX_BURST);

   typedef enum logic [2:0] {S_IDLE, S_TURN, S_READ, S_WRITE, S_FLUSH} state_t;

   state_t        r_state, w_next;
   logic          r_wr, r_oe, r_rd, r_siwu, r_drive;
   logic [7:0]    r_tx_byte;
   logic          r_tx_full;
   logic [7:0]    r_mem [RX_DEPTH];
   logic [AW-1:0] r_wp, r_rp;
   logic [LW-1:0] r_level, w_level_next;
   logic [BW-1:0] r_burst, w_burst_inc;
   logic          r_last_wr, r_flush_pend;
   logic          w_push, w_pop, w_accept, w_load, w_rd_want, w_wr_want;

   assign w_accept     = (r_state == S_WRITE) && !r_wr && !txe;
   assign tx_ready     = !r_tx_full || w_accept;
   assign w_load       = tx_valid && tx_ready;
   assign w_push       = (r_state == S_READ) && !r_rd && !rxf;
   assign w_pop        = rx_ready && rx_valid;
   assign w_level_next = r_level + LW'(w_push) - LW'(w_pop);
   assign w_burst_inc  = r_burst + BW'(1);
   assign w_rd_want    = !rxf && (r_level != DEPTH_L);
   assign w_wr_want    = r_tx_full && !txe;

   assign adbus    = r_drive ? r_tx_byte : 'z;
   assign wr       = r_wr;
   assign oe       = r_oe;
   assign rd       = r_rd;
   assign siwu     = r_siwu;
   assign rx_valid = (r_level != '0);
   assign rx_data  = r_mem[r_rp];
   assign rx_level = r_level;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            // On contention, the direction not used last wins.
            if (w_rd_want && (!w_wr_want || r_last_wr))
               w_next = S_TURN;
            else if (w_wr_want)
               w_next = S_WRITE;
            else if (r_flush_pend && !r_tx_full)
               w_next = S_FLUSH;
         end
         S_TURN:  w_next = S_READ;
         S_READ: begin
            if (rxf || (w_level_next == DEPTH_L) || (w_burst_inc == BURST_L))
               w_next = S_IDLE;
         end
         S_WRITE: begin
            if (!w_accept || !w_load || (w_burst_inc == BURST_L))
               w_next = S_IDLE;
         end
         S_FLUSH: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_wr         <= 1'b1;
         r_oe         <= 1'b1;
         r_rd         <= 1'b1;
         r_siwu       <= 1'b1;
         r_drive      <= 1'b0;
         r_tx_byte    <= '0;
         r_tx_full    <= 1'b0;
         r_wp         <= '0;
         r_rp         <= '0;
         r_level      <= '0;
         r_burst      <= '0;
         r_last_wr    <= 1'b1;
         r_flush_pend <= 1'b0;
      end else begin
         r_state <= w_next;
         // Strobes are decoded from the next state so every pin changes straight off a flop.
         r_wr    <= (w_next != S_WRITE);
         r_drive <= (w_next == S_WRITE);
         r_oe    <= !((w_next == S_TURN) || (w_next == S_READ));
         r_rd    <= (w_next != S_READ);
         r_siwu  <= (w_next != S_FLUSH);

         if (w_load) begin
            r_tx_byte <= tx_data;
            r_tx_full <= 1'b1;
         end else if (w_accept) begin
            r_tx_full <= 1'b0;
         end

         if (w_push) r_wp <= r_wp + AW'(1);
         if (w_pop)  r_rp <= r_rp + AW'(1);
         r_level <= w_level_next;

         if (w_next == S_IDLE)
            r_burst <= '0;
         else if (w_push || w_accept)
            r_burst <= w_burst_inc;

         if (w_next == S_TURN)
            r_last_wr <= 1'b0;
         else if (w_next == S_WRITE)
            r_last_wr <= 1'b1;

         r_flush_pend <= flush || (r_flush_pend && (r_state != S_FLUSH));
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp] <= adbus;
   end

endmodule

// File: tb/tb_ft232h_host.sv
// Directed bench for ft232h_host: a behavioural FT232H models both FIFO sides, and every
// expected value below is worked out by hand from the cycle timing of the interface.
module tb_ft232h_host;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   wire  [7:0] adbus;
   logic       txe = 1'b1;
   logic       wr, siwu, oe, rd, rxf;
   logic [7:0] tx_data;
   logic       tx_valid, tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready = 1'b0;
   logic       flush = 1'b0;
   logic [4:0] rx_level;

   int errors = 0;
   int checks = 0;

   // TX source stream
   logic [7:0] tx_mem [64];
   logic [5:0] tx_i = '0;
   logic [5:0] tx_n = '0;
   // FT232H receive side (bytes the chip offers to the FPGA)
   logic [7:0] ft_mem [64];
   logic [5:0] ft_i = '0;
   logic [5:0] ft_n = '0;
   // Bytes the FT232H accepted from the FPGA
   logic [7:0] wlog [64];
   logic [5:0] wcnt = '0;

   ft232h_host #(.RX_DEPTH(16), .MAX_BURST(4)) dut (
      .clk(clk), .rst(rst), .adbus(adbus), .txe(txe), .wr(wr), .siwu(siwu),
      .rxf(rxf), .oe(oe), .rd(rd), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .flush(flush), .rx_level(rx_level)
   );

   always #5 clk = ~clk;

   assign tx_valid = (tx_i < tx_n);
   assign tx_data  = tx_mem[tx_i];
   assign rxf      = !(ft_i < ft_n);
   assign adbus    = !oe ? ft_mem[ft_i] : 'z;

   always @(posedge clk) begin
      if (!rst && tx_valid && tx_ready) tx_i <= tx_i + 6'd1;
      if (!rd && !rxf) ft_i <= ft_i + 6'd1;
      if (!wr && !txe) begin
         wlog[wcnt] <= adbus;
         wcnt       <= wcnt + 6'd1;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         checks++;
         assert (!(!oe && !wr)) else begin
            errors++;
            $error("FAIL inv_oe_drive: oe=%b wr=%b, required not both low", oe, wr);
         end
         checks++;
         assert (!(!wr && !rd)) else begin
            errors++;
            $error("FAIL inv_wr_rd: wr=%b rd=%b, required not both low", wr, rd);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, required $finish");
      $fatal(1);
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h, required %0h", tag, obs, exp);
      end
   endtask

   task automatic pop_chk(input logic [7:0] exp);
      int n = 0;
      while (!rx_valid && n < 50) begin
         tick();
         n++;
      end
      chk("rx_valid_pop", rx_valid, 1);
      chk("rx_data", rx_data, exp);
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
   endtask

   initial begin
      // Reset state
      tick(2);
      chk("rst_wr", wr, 1);
      chk("rst_oe", oe, 1);
      chk("rst_rd", rd, 1);
      chk("rst_siwu", siwu, 1);
      chk("rst_tx_ready", tx_ready, 1);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_rx_level", rx_level, 0);
      rst = 1'b0;
      tick();

      // Write burst 0x11,0x22,0x33
      txe = 1'b0;
      tx_mem[0] = 8'h11; tx_mem[1] = 8'h22; tx_mem[2] = 8'h33;
      tx_n = 6'd3;
      tick(); chk("wb_wr_load", wr, 1);
      tick(); chk("wb_wr0", wr, 0); chk("wb_bus0", adbus, 8'h11);
      tick(); chk("wb_wr1", wr, 0); chk("wb_bus1", adbus, 8'h22);
      tick(); chk("wb_wr2", wr, 0); chk("wb_bus2", adbus, 8'h33);
      tick(); chk("wb_wr_end", wr, 1); chk("wb_tx_ready", tx_ready, 1);

      // txe stall while 0x22 is presented
      tx_mem[3] = 8'h11; tx_mem[4] = 8'h22; tx_mem[5] = 8'h33;
      tx_n = 6'd6;
      tick();
      tick(); chk("st_bus0", adbus, 8'h11);
      tick(); chk("st_bus1", adbus, 8'h22);
      txe = 1'b1;
      tick(); chk("st_wr_stall", wr, 1); chk("st_tx_ready", tx_ready, 0);
      tick(); chk("st_wr_hold", wr, 1);
      txe = 1'b0;
      tick(); chk("st_wr_resume", wr, 0); chk("st_bus_redrive", adbus, 8'h22);
      tick(); chk("st_bus2", adbus, 8'h33);
      tick(); chk("st_wr_end", wr, 1); chk("st_wcnt", wcnt, 6);
      chk("wlog0", wlog[0], 8'h11); chk("wlog1", wlog[1], 8'h22);
      chk("wlog2", wlog[2], 8'h33); chk("wlog3", wlog[3], 8'h11);
      chk("wlog4", wlog[4], 8'h22); chk("wlog5", wlog[5], 8'h33);
      txe = 1'b1;

      // Read burst 0xA0..0xA4 (MAX_BURST=4 splits it 4+1)
      for (int i = 0; i < 5; i++) ft_mem[i] = 8'hA0 + 8'(i);
      ft_n = 6'd5;
      tick(); chk("rb_oe_turn", oe, 0); chk("rb_rd_turn", rd, 1);
      tick(); chk("rb_oe_read", oe, 0); chk("rb_rd_read", rd, 0);
      tick(4); chk("rb_rd_burst", rd, 1); chk("rb_level4", rx_level, 4);
      tick(4); chk("rb_oe_end", oe, 1); chk("rb_rd_end", rd, 1);
      chk("rb_level5", rx_level, 5);
      for (int i = 0; i < 5; i++) pop_chk(8'hA0 + 8'(i));
      chk("rb_level0", rx_level, 0);

      // RX backpressure: 20 bytes offered into a 16-entry FIFO
      for (int i = 0; i < 20; i++) ft_mem[5 + i] = 8'(i);
      ft_n = 6'd25;
      tick(40);
      chk("bp_level", rx_level, 16); chk("bp_rd", rd, 1); chk("bp_oe", oe, 1);
      chk("bp_taken", ft_i, 21);
      pop_chk(8'h00);
      tick(8);
      chk("bp_level_refill", rx_level, 16); chk("bp_taken2", ft_i, 22);
      for (int i = 1; i < 20; i++) pop_chk(8'(i));
      chk("bp_taken_all", ft_i, 25); chk("bp_level_end", rx_level, 0);

      // Contention after reset, MAX_BURST=4
      rst = 1'b1;
      for (int i = 0; i < 8; i++) tx_mem[6 + i] = 8'hB0 + 8'(i);
      for (int i = 0; i < 8; i++) ft_mem[25 + i] = 8'hC0 + 8'(i);
      tx_n = 6'd14;
      tick();
      rst = 1'b0;
      tick(); chk("ct_held", tx_ready, 0);
      txe = 1'b0;
      ft_n = 6'd33;
      tick(); chk("ct_read_first", oe, 0); chk("ct_wr_idle", wr, 1);
      tick(5); chk("ct_r1_oe", oe, 1); chk("ct_r1_level", rx_level, 4);
      tick(); chk("ct_w1_wr", wr, 0); chk("ct_w1_oe", oe, 1); chk("ct_w1_bus", adbus, 8'hB0);
      tick(4); chk("ct_w1_end", wr, 1); chk("ct_w1_wcnt", wcnt, 10);
      tick(); chk("ct_r2_oe", oe, 0); chk("ct_r2_wr", wr, 1);
      tick(5); chk("ct_r2_level", rx_level, 8); chk("ct_r2_rd", rd, 1);
      tick(); chk("ct_w2_wr", wr, 0);
      tick(4); chk("ct_w2_end", wr, 1); chk("ct_w2_wcnt", wcnt, 14);
      for (int i = 0; i < 8; i++) chk("ct_wlog", wlog[6 + i], 8'hB0 + 8'(i));
      for (int i = 0; i < 8; i++) pop_chk(8'hC0 + 8'(i));

      // Flush requested during a write burst
      tx_mem[14] = 8'hD0; tx_mem[15] = 8'hD1;
      tx_n = 6'd16;
      tick(); chk("fl_siwu0", siwu, 1);
      tick(); chk("fl_siwu1", siwu, 1);
      flush = 1'b1;
      tick(); chk("fl_siwu2", siwu, 1); chk("fl_wr2", wr, 0);
      tick(); chk("fl_siwu3", siwu, 1); chk("fl_wr3", wr, 1);
      flush = 1'b0;
      tick(); chk("fl_pulse", siwu, 0);
      for (int i = 0; i < 3; i++) begin
         tick(); chk("fl_single", siwu, 1);
      end
      txe = 1'b1;

      // Reset asserted mid-READ
      for (int i = 0; i < 4; i++) ft_mem[33 + i] = 8'hE0 + 8'(i);
      ft_n = 6'd37;
      tick(4); chk("mr_rd", rd, 0); chk("mr_oe", oe, 0); chk("mr_level", rx_level, 2);
      #2 rst = 1'b1;
      #1;
      chk("mr_rst_rd", rd, 1); chk("mr_rst_oe", oe, 1);
      chk("mr_rst_level", rx_level, 0); chk("mr_rst_valid", rx_valid, 0);
      tick();
      rst = 1'b0;
      tick(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ft232h_host.md
Name: ft232h_host

Overview:
- FPGA-side master for the FT232H 245 synchronous FIFO interface.
- Moves bytes from an internal valid/ready TX stream onto adbus with the wr strobe.
- Pulls bytes from the FT232H with oe and rd into an internal RX FIFO.
- Arbitrates the shared bidirectional bus, handles turnaround, and provides the send-immediate (siwu) flush.
- Sits between the USB bridge pins and the SoC debug/DMA byte streams.

Parameters:
RX_DEPTH, 16, RX FIFO entries; power of two, minimum 4.
MAX_BURST, 32, maximum bytes per read or write burst before the direction is re-arbitrated.

Ports:
clk  input  1  interface clock; same edge relationship as the FT232H clkout.
rst  input  1  asynchronous, active-high reset.
adbus  inout  8  FT232H data bus; driven only in WRITE, high-Z otherwise.
txe  input  1  active-low; 0 = FT232H can accept a byte.
wr  output  1  active-low write strobe.
siwu  output  1  active-low send-immediate.
rxf  input  1  active-low; 0 = FT232H has a byte.
oe  output  1  active-low FT232H output enable.
rd  output  1  active-low read strobe.
tx_data  input  8  byte to send.
tx_valid  input  1  tx_data valid.
tx_ready  output  1  holding register can accept a byte.
rx_data  output  8  head of RX FIFO.
rx_valid  output  1  RX FIFO non-empty.
rx_ready  input  1  consumer pops the head when rx_valid is also high.
flush  input  1  one-cycle request to assert siwu.
rx_level  output  $clog2(RX_DEPTH)+1  RX FIFO occupancy.

Behaviour:
- Reset (async): wr=oe=rd=siwu=1, adbus=Z, state IDLE, TX holding register empty (tx_ready=1), RX FIFO empty (rx_valid=0, rx_level=0), flush pending cleared, burst counter 0, last-direction flag = write (so read wins first). Reset mid-burst drops the held byte and RX contents; strobes go high immediately.
- All pin outputs are registered.
- Free space: rx_free = RX_DEPTH - rx_level.
- TX holding register:
  - One byte deep.
  - Loads on tx_valid && tx_ready.
  - tx_ready = empty OR the current byte is being accepted this edge (a back-to-back burst is possible).
- States: IDLE, TURN, READ, WRITE, FLUSH.
- IDLE: all strobes high, bus Z. Exit rules:
  - Read wanted: rxf==0 && rx_free>=1.
  - Write wanted: holding full && txe==0.
  - Both wanted: take the direction not used last.
  - Read wanted -> TURN.
  - Write wanted -> WRITE.
  - Neither wanted, and flush pending with holding empty -> FLUSH.
- TURN: oe=0, rd=1, bus Z for exactly one cycle, then READ.
- READ:
  - oe=0, rd=0.
  - Capture rule: each posedge with rd==0 && rxf==0 pushes adbus into the RX FIFO and increments the burst counter.
  - Exit when any of: rxf==1 sampled; rx_free after this edge ==0; burst count ==MAX_BURST.
  - On exit: rd=1, oe=1 next cycle, state IDLE. The bus is never driven until at least one IDLE cycle with oe=1 has elapsed.
  - The FIFO never overflows; pushes while full are impossible by construction.
- WRITE:
  - wr=0, adbus = held byte.
  - Accept rule: a byte is accepted at a posedge with wr==0 && txe==0; the held byte is cleared or reloaded and the burst counter increments.
  - txe==1 at an edge: byte not accepted and retained; wr=1 and bus Z next cycle, state IDLE.
  - Holding empty after the edge, or burst ==MAX_BURST: wr=1, IDLE.
- FLUSH: siwu=0 for exactly one cycle, then IDLE; clears flush pending.
  - flush arriving while busy is latched; multiple requests collapse to one.
- RX pop: rx_data reflects the head combinationally from the FIFO storage.
  - Simultaneous push and pop keeps rx_level unchanged.
  - Read and write pointers wrap modulo RX_DEPTH.
- Invariants:
  - oe==0 and adbus driven never occur in the same cycle.
  - wr==0 and rd==0 never occur in the same cycle.

Test Plan:
- Write burst: push 0x11,0x22,0x33 with txe=0 -> wr low 3 consecutive cycles, adbus shows 0x11,0x22,0x33 on successive edges, then wr=1 and bus Z.
- txe stall: txe rises on the cycle 0x22 is presented -> 0x22 not counted; wr=1; when txe=0 again, 0x22 is re-driven first and no byte is duplicated or lost.
- Read burst: model presents 0xA0..0xA4 with rxf=0 -> oe low one cycle before rd; RX FIFO holds 5 bytes in order; rx_level=5; oe/rd high after rxf=1.
- RX backpressure: RX_DEPTH=16, rx_ready=0, 20 bytes offered -> exactly 16 captured, rd=1 afterwards; popping one byte resumes the read with 0x10th byte next.
- Contention: TX byte held and rxf=0 simultaneously after reset -> read first; MAX_BURST=4 with both pending -> alternating 4-read and 4-write bursts; adbus never driven while oe=0 (assertion).
- Flush and reset: flush during a write burst -> single siwu low pulse after the holding register empties. rst asserted mid-READ -> rd/oe high in the same cycle, rx_level=0.
